// File: rtl/col_burst_ctrl.sv
// Column burst controller: starts a skewed read burst across N_CH column FIFOs
// and issues per-channel read / shift-register strobes from a shared counter.
module col_burst_ctrl #(
  parameter int N_CH       = 4,
  parameter int W_ADDR     = 8,
  parameter int BURST_LEN  = 9,
  parameter int SKEW       = 1,
  parameter int THRESHOLD  = 10,
  parameter int AUTO_START = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [N_CH-1:0]            i_fifo_empty,
  input  logic [N_CH*(W_ADDR+1)-1:0] i_occupants,
  input  logic                       i_start,
  input  logic                       i_stall,
  output logic [N_CH-1:0]            o_read_enable,
  output logic [N_CH-1:0]            o_sr_enable,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_underflow
);

  localparam int TOTAL = BURST_LEN + (N_CH - 1) * SKEW;
  localparam int TW    = $clog2(TOTAL + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TOTAL - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] t, t_nxt;
  logic          occ_ok;
  logic          start_cond;
  logic [31:0]   occ_ext;
  logic [TW-1:0] lo, hi;

  // Occupancy compared at 32 bits so a large THRESHOLD is never truncated.
  always_comb begin
    occ_ok  = 1'b1;
    occ_ext = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      occ_ext = 32'(i_occupants[k*(W_ADDR+1) +: W_ADDR+1]);
      if (occ_ext < 32'(THRESHOLD)) occ_ok = 1'b0;
    end
  end

  assign start_cond = ~|i_fifo_empty && ((AUTO_START != 0) ? occ_ok : i_start);

  // Window bounds are evaluated at the width of t; the largest bound is TOTAL.
  always_comb begin
    o_sr_enable = '0;
    lo          = '0;
    hi          = '0;
    if (state == RUN && !i_stall) begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        lo = TW'(k * SKEW);
        hi = TW'(k * SKEW + BURST_LEN);
        if (t >= lo && t < hi) o_sr_enable[k] = 1'b1;
      end
    end
  end

  assign o_read_enable = o_sr_enable & ~i_fifo_empty;
  assign o_busy        = (state == RUN);
  assign o_done        = (state == DONE);

  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    case (state)
      IDLE: begin
        if (start_cond) begin
          state_nxt = RUN;
          t_nxt     = '0;
        end
      end
      RUN: begin
        if (!i_stall) begin
          if (t == T_LAST) begin
            state_nxt = DONE;
            t_nxt     = '0;
          end else begin
            t_nxt = t + TW'(1);
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        t_nxt     = '0;
      end
      default: begin
        state_nxt = IDLE;
        t_nxt     = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      t           <= '0;
      o_underflow <= 1'b0;
    end else begin
      state <= state_nxt;
      t     <= t_nxt;
      if (|(o_sr_enable & i_fifo_empty)) o_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_col_burst_ctrl.sv
// Directed bench for col_burst_ctrl: auto-start instance plus a manual-start instance.
module tb_col_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  empty;
  logic [35:0] occ;
  logic        start;
  logic        stall;

  logic [3:0]  rd, sr;
  logic        busy, done, uf;
  logic [3:0]  m_rd, m_sr;
  logic        m_busy, m_done, m_uf;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  col_burst_ctrl #(.N_CH(4), .W_ADDR(8), .BURST_LEN(9), .SKEW(1), .THRESHOLD(10), .AUTO_START(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_fifo_empty(empty), .i_occupants(occ),
    .i_start(start), .i_stall(stall), .o_read_enable(rd), .o_sr_enable(sr),
    .o_busy(busy), .o_done(done), .o_underflow(uf)
  );

  col_burst_ctrl #(.N_CH(4), .W_ADDR(8), .BURST_LEN(9), .SKEW(1), .THRESHOLD(10), .AUTO_START(0)) dut_m (
    .i_clk(clk), .i_rst_n(rst_n), .i_fifo_empty(empty), .i_occupants(occ),
    .i_start(start), .i_stall(stall), .o_read_enable(m_rd), .o_sr_enable(m_sr),
    .o_busy(m_busy), .o_done(m_done), .o_underflow(m_uf)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_occ(input logic [8:0] o0, input logic [8:0] o1,
                         input logic [8:0] o2, input logic [8:0] o3);
    occ = {o3, o2, o1, o0};
  endtask

  // Expected strobes for burst counter value te with SKEW=1, BURST_LEN=9.
  function automatic logic [3:0] win(input int te);
    logic [3:0] w;
    w = '0;
    for (int k = 0; k < 4; k++)
      if (te >= k && te < k + 9) w[k] = 1'b1;
    return w;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; set_occ(10, 10, 10, 10); empty = '0; start = 1'b0; stall = 1'b0;
    tick; tick;
    checks++; if (sr !== 4'b0) $display("FAIL reset_sr got=%b exp=0000", sr); else passes++;
    checks++; if (rd !== 4'b0) $display("FAIL reset_rd got=%b exp=0000", rd); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else passes++;
    checks++; if (uf !== 1'b0) $display("FAIL reset_uf got=%b exp=0", uf); else passes++;
    set_occ(0, 0, 0, 0);
    rst_n = 1'b1;
    tick;
    checks++; if (busy !== 1'b0) $display("FAIL reset_idle_busy got=%b exp=0", busy); else passes++;
  endtask

  task automatic test_auto;
    logic [3:0] es;
    set_occ(10, 10, 10, 10);
    tick;
    set_occ(0, 0, 0, 0);
    for (int c = 0; c <= 13; c++) begin
      #1;
      es = (c <= 11) ? win(c) : 4'b0;
      checks++; if (sr !== es) $display("FAIL auto_sr c=%0d got=%b exp=%b", c, sr, es); else passes++;
      checks++; if (rd !== es) $display("FAIL auto_rd c=%0d got=%b exp=%b", c, rd, es); else passes++;
      checks++; if (busy !== (c <= 11)) $display("FAIL auto_busy c=%0d got=%b exp=%b", c, busy, c <= 11); else passes++;
      checks++; if (done !== (c == 12)) $display("FAIL auto_done c=%0d got=%b exp=%b", c, done, c == 12); else passes++;
      tick;
    end
  endtask

  task automatic test_threshold_miss;
    set_occ(10, 10, 9, 10);
    for (int c = 0; c < 20; c++) begin
      #1;
      checks++; if (sr !== 4'b0) $display("FAIL thr_sr c=%0d got=%b exp=0000", c, sr); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL thr_busy c=%0d got=%b exp=0", c, busy); else passes++;
      tick;
    end
    set_occ(0, 0, 0, 0);
    tick;
  endtask

  task automatic test_stall;
    logic [3:0] es;
    int te;
    int cnt [4];
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    set_occ(10, 10, 10, 10);
    tick;
    set_occ(0, 0, 0, 0);
    for (int c = 0; c <= 15; c++) begin
      stall = (c == 4 || c == 5);
      #1;
      te = (c < 4) ? c : ((c < 6) ? 4 : c - 2);
      es = (stall || c > 13) ? 4'b0 : win(te);
      checks++; if (sr !== es) $display("FAIL stall_sr c=%0d got=%b exp=%b", c, sr, es); else passes++;
      checks++; if (busy !== (c <= 13)) $display("FAIL stall_busy c=%0d got=%b exp=%b", c, busy, c <= 13); else passes++;
      checks++; if (done !== (c == 14)) $display("FAIL stall_done c=%0d got=%b exp=%b", c, done, c == 14); else passes++;
      for (int k = 0; k < 4; k++) if (sr[k] === 1'b1) cnt[k]++;
      tick;
    end
    stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (cnt[k] != 9) $display("FAIL stall_pulses ch=%0d got=%0d exp=9", k, cnt[k]); else passes++;
    end
  endtask

  task automatic test_underflow;
    logic [3:0] es;
    set_occ(10, 10, 10, 10);
    empty = '0;
    tick;
    set_occ(0, 0, 0, 0);
    for (int c = 0; c <= 14; c++) begin
      empty = (c >= 5) ? 4'b0100 : 4'b0000;
      #1;
      es = (c <= 11) ? win(c) : 4'b0;
      checks++; if (sr !== es) $display("FAIL uf_sr c=%0d got=%b exp=%b", c, sr, es); else passes++;
      checks++; if (rd !== (es & ~empty)) $display("FAIL uf_rd c=%0d got=%b exp=%b", c, rd, es & ~empty); else passes++;
      checks++; if (uf !== (c >= 6)) $display("FAIL uf_flag c=%0d got=%b exp=%b", c, uf, c >= 6); else passes++;
      checks++; if (done !== (c == 12)) $display("FAIL uf_done c=%0d got=%b exp=%b", c, done, c == 12); else passes++;
      tick;
    end
    empty = '0;
    tick;
  endtask

  task automatic test_reset_mid;
    set_occ(10, 10, 10, 10);
    tick;
    set_occ(0, 0, 0, 0);
    for (int c = 0; c <= 6; c++) begin
      #1;
      checks++; if (sr !== win(c)) $display("FAIL rstmid_sr c=%0d got=%b exp=%b", c, sr, win(c)); else passes++;
      checks++; if (busy !== 1'b1) $display("FAIL rstmid_busy c=%0d got=%b exp=1", c, busy); else passes++;
      if (c == 6) begin
        checks++; if (uf !== 1'b1) $display("FAIL rstmid_uf_before got=%b exp=1", uf); else passes++;
        rst_n = 1'b0;
      end
      tick;
    end
    #1;
    checks++; if (sr !== 4'b0) $display("FAIL rstmid_sr_after got=%b exp=0000", sr); else passes++;
    checks++; if (rd !== 4'b0) $display("FAIL rstmid_rd_after got=%b exp=0000", rd); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy_after got=%b exp=0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL rstmid_done_after got=%b exp=0", done); else passes++;
    checks++; if (uf !== 1'b0) $display("FAIL rstmid_uf_after got=%b exp=0", uf); else passes++;
    rst_n = 1'b1;
    set_occ(10, 10, 10, 10);
    tick;
    set_occ(0, 0, 0, 0);
    #1;
    checks++; if (busy !== 1'b1) $display("FAIL restart_busy got=%b exp=1", busy); else passes++;
    checks++; if (sr !== 4'b0001) $display("FAIL restart_sr got=%b exp=0001", sr); else passes++;
    for (int c = 1; c <= 13; c++) tick;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL restart_end_busy got=%b exp=0", busy); else passes++;
  endtask

  task automatic test_manual;
    logic [3:0] es;
    int ndone;
    ndone = 0;
    set_occ(3, 3, 3, 3);
    empty = '0;
    start = 1'b1;
    tick;
    for (int c = 0; c <= 15; c++) begin
      start = (c == 4);
      #1;
      es = (c <= 11) ? win(c) : 4'b0;
      checks++; if (m_sr !== es) $display("FAIL man_sr c=%0d got=%b exp=%b", c, m_sr, es); else passes++;
      checks++; if (m_busy !== (c <= 11)) $display("FAIL man_busy c=%0d got=%b exp=%b", c, m_busy, c <= 11); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL man_auto_idle c=%0d got=%b exp=0", c, busy); else passes++;
      if (m_done === 1'b1) ndone++;
      tick;
    end
    start = 1'b0;
    checks++; if (ndone != 1) $display("FAIL man_done_count got=%0d exp=1", ndone); else passes++;
  endtask

  initial begin
    test_reset;
    test_auto;
    test_threshold_miss;
    test_stall;
    test_underflow;
    test_reset_mid;
    test_manual;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/col_burst_ctrl.md
COL_BURST_CTRL -- requirements
Module: col_burst_ctrl

Interface
REQ-001 SHALL have parameter N_CH, default 4, meaning the number of column FIFO channels (N_CH >= 1).
REQ-002 SHALL have parameter W_ADDR, default 8, meaning the FIFO address width; occupancy is W_ADDR+1 bits.
REQ-003 SHALL have parameter BURST_LEN, default 9, meaning reads per channel per burst (>= 1).
REQ-004 SHALL have parameter SKEW, default 1, meaning the start-cycle offset between channel k and k+1 (>= 0).
REQ-005 SHALL have parameter THRESHOLD, default 10, meaning the per-channel occupancy needed for auto start.
REQ-006 SHALL have parameter AUTO_START, default 1, meaning 1 = occupancy-triggered start and 0 = i_start-triggered start.
REQ-007 SHALL have port i_clk, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-008 SHALL have port i_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-009 SHALL have port i_fifo_empty, input, N_CH bits: per-channel FIFO empty flag.
REQ-010 SHALL have port i_occupants, input, N_CH*(W_ADDR+1) bits: packed occupancy, channel k at [k*(W_ADDR+1) +: W_ADDR+1].
REQ-011 SHALL have port i_start, input, 1 bit: manual start request, used only when AUTO_START=0.
REQ-012 SHALL have port i_stall, input, 1 bit: downstream stall.
REQ-013 SHALL have port o_read_enable, output, N_CH bits: per-channel FIFO read strobe.
REQ-014 SHALL have port o_sr_enable, output, N_CH bits: per-channel shift-register advance.
REQ-015 SHALL have port o_busy, output, 1 bit: high while in RUN.
REQ-016 SHALL have port o_done, output, 1 bit: one-cycle pulse at burst completion.
REQ-017 SHALL have port o_underflow, output, 1 bit: sticky error flag.

Function
REQ-018 SHALL implement states IDLE, RUN and DONE, plus a burst counter t of width clog2(TOTAL+1), where TOTAL = BURST_LEN + (N_CH-1)*SKEW.
REQ-019 SHALL in IDLE evaluate the start condition: all i_fifo_empty bits are 0, AND (AUTO_START=1: every channel occupancy >= THRESHOLD; AUTO_START=0: i_start=1).
REQ-020 SHALL, when the start condition is true at a rising edge in IDLE, move to RUN with t=0 at that edge; i_stall is not part of the start condition.
REQ-021 SHALL in RUN with i_stall=0 set the window for channel k as k*SKEW <= t < k*SKEW+BURST_LEN; decode is combinational from registered t, state and i_stall.
REQ-022 SHALL drive o_sr_enable[k] = 1 in RUN when i_stall=0 and channel k is in its window.
REQ-023 SHALL drive o_read_enable[k] = o_sr_enable[k] AND NOT i_fifo_empty[k].
REQ-024 SHALL in RUN increment t only on cycles with i_stall=0; with i_stall=1, all enables are 0 and t holds.
REQ-025 SHALL move from RUN to DONE on a non-stalled cycle with t = TOTAL-1.
REQ-026 SHALL hold o_done=1 for exactly the one DONE cycle, then go to IDLE; a start condition present in DONE is ignored and re-evaluated in IDLE.
REQ-027 SHALL hold o_busy=1 exactly while in RUN.
REQ-028 SHALL ignore i_start and occupancy changes during RUN and DONE.
REQ-029 SHALL register o_underflow and set it the cycle after any cycle where o_sr_enable[k]=1 and i_fifo_empty[k]=1; it then stays set until reset.
REQ-030 SHALL assert exactly BURST_LEN o_sr_enable pulses per channel per burst, regardless of stalls.
REQ-031 SHALL be free of arithmetic overflow: all window bounds are computed at the width of t.

Reset
REQ-032 SHALL, on a rising edge with i_rst_n=0, enter IDLE, clear t and clear o_underflow, with o_read_enable, o_sr_enable, o_busy and o_done all 0 from the following cycle.
REQ-033 SHALL let reset abort a burst at any point; no partial-burst state survives.

Verification
All scenarios use N_CH=4, BURST_LEN=9, SKEW=1, THRESHOLD=10, so TOTAL=12; cycle 0 is the first cycle after the triggering edge.
REQ-034 Auto start: all occupants=10, empty=0 -> ch0 enables in cycles 0-8, ch3 in cycles 3-11, o_busy in cycles 0-11, o_done in cycle 12, IDLE in cycle 13.
REQ-035 Threshold miss: occupants {10,10,9,10} held 20 cycles -> no enable, o_busy=0 throughout.
REQ-036 Stall: i_stall=1 in cycles 4-5 -> all enables 0 in cycles 4-5, o_done in cycle 14, each channel still gets 9 o_sr_enable pulses.
REQ-037 Underflow: i_fifo_empty[2]=1 from cycle 5 -> o_read_enable[2]=0 and o_sr_enable[2]=1 in cycles 5-10, o_underflow=1 from cycle 6 and stays 1 after o_done.
REQ-038 Reset mid-burst: i_rst_n=0 sampled at the edge ending cycle 6 -> all outputs 0 from cycle 7, o_underflow cleared, a new start is accepted after release.
REQ-039 Manual mode (AUTO_START=0): i_start pulse with occupants=3 -> burst starts; i_start re-pulsed in cycle 4 -> ignored, exactly one o_done.
